// File: rtl/gray_sync_decoder_if.sv
// ---------------------------------------------------------------------------
// gray_sync_decoder_if
// Purpose : bundles the data/status signals of gray_sync_decoder so that the
//           design and its driver connect through one port.
// Signals :
//   gray_in   [WIDTH] Gray word from the foreign clock domain (driver -> dut)
//   err_clr           synchronous clear of sticky err        (driver -> dut)
//   gray_sync [WIDTH] last synchronizer stage                (dut -> driver)
//   bin_out   [WIDTH] registered binary decode               (dut -> driver)
//   change            one-cycle pulse on a new value         (dut -> driver)
//   up                step direction, valid with change      (dut -> driver)
//   err               sticky illegal-step flag               (dut -> driver)
// Modports: master = driver side, slave = decoder side.
// ---------------------------------------------------------------------------
interface gray_sync_decoder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             err_clr;
  logic [WIDTH-1:0] gray_sync;
  logic [WIDTH-1:0] bin_out;
  logic             change;
  logic             up;
  logic             err;

  modport master (
    output gray_in,
    output err_clr,
    input  gray_sync,
    input  bin_out,
    input  change,
    input  up,
    input  err
  );

  modport slave (
    input  gray_in,
    input  err_clr,
    output gray_sync,
    output bin_out,
    output change,
    output up,
    output err
  );
endinterface

// File: rtl/gray_sync_decoder.sv
// ---------------------------------------------------------------------------
// gray_sync_decoder
// Purpose : receive side of a Gray-coded domain crossing. Synchronizes the
//           Gray word into clk, decodes it to binary, and reports each new
//           value with a one-cycle change pulse plus step direction.
// Parameters:
//   WIDTH       (>=2) word width
//   SYNC_STAGES (>=2) number of synchronizer flops
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  gray_sync_decoder_if.slave (gray_in, err_clr in;
//        gray_sync, bin_out, change, up, err out)
// Build option:
//   GRAY_SYNC_ERR_EN  when defined, illegal steps (anything other than +/-1
//                     mod 2^WIDTH) set a sticky err, cleared by err_clr.
//                     When undefined, err is tied to 0 and err_clr ignored.
// ---------------------------------------------------------------------------
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  gray_sync_decoder_if.slave     bus
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(SYNC_STAGES + 1);

  // Synchronizer chain: plain flops, nothing between stages.
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= bus.gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  logic [WIDTH-1:0] w_gray;
  assign w_gray = r_sync[SYNC_STAGES-1];

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above
  // it, written as a reduction per bit to avoid a bit-serial chain.
  logic [WIDTH-1:0] w_bin;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign w_bin[gi] = ^w_gray[WIDTH-1:gi];
    end
  endgenerate

  // Priming counter: outputs stay quiet until the synchronizer and bin_out
  // hold values that really came from gray_in after reset.
  logic [CNT_W-1:0] r_prime_cnt;
  logic             w_primed;
  assign w_primed = (r_prime_cnt == PRIME_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prime_cnt <= '0;
    end else if (!w_primed) begin
      r_prime_cnt <= r_prime_cnt + 1'b1;
    end
  end

  // Step classification against the currently registered value.
  logic [WIDTH-1:0] r_bin;
  logic             r_change;
  logic             r_up;
  logic             w_differ;
  logic             w_step_up;
  logic             w_step_dn;
  logic             w_illegal;

  assign w_differ  = (w_bin != r_bin);
  assign w_step_up = (w_bin == r_bin + 1'b1);   // wraps mod 2^WIDTH
  assign w_step_dn = (w_bin == r_bin - 1'b1);
  assign w_illegal = w_differ && !w_step_up && !w_step_dn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin    <= '0;
      r_change <= 1'b0;
      r_up     <= 1'b0;
    end else begin
      r_bin <= w_bin;
      if (w_primed) begin
        r_change <= w_differ;
        // up only updates alongside a pulse; otherwise it keeps its value.
        if (w_differ) r_up <= w_step_up;
      end else begin
        r_change <= 1'b0;
        r_up     <= 1'b0;
      end
    end
  end

`ifdef GRAY_SYNC_ERR_EN
  logic r_err;

  // Set has priority over clear so an illegal step is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_primed && w_illegal) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = bus.err_clr ^ w_illegal;
  assign bus.err      = 1'b0;
`endif

  assign bus.gray_sync = w_gray;
  assign bus.bin_out   = r_bin;
  assign bus.change    = r_change;
  assign bus.up        = r_up;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_gray_sync_decoder
// Directed checks of gray_sync_decoder with WIDTH=4, SYNC_STAGES=2.
// Expected err depends on whether GRAY_SYNC_ERR_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_gray_sync_decoder;

  localparam int WIDTH = 4;
  localparam int SYNC_STAGES = 2;

`ifdef GRAY_SYNC_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  gray_sync_decoder_if #(.WIDTH(WIDTH)) bus ();

  gray_sync_decoder #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
      $display("t=%0t chk %-14s act=%0h exp=%0h ok", $time, tag, act, exp);
    end else begin
      $display("t=%0t FAIL %-14s act=%0h exp=%0h", $time, tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a new Gray word, then wait the SYNC_STAGES+1 edges until it lands.
  task automatic apply(input logic [WIDTH-1:0] g);
    bus.gray_in = g;
    repeat (SYNC_STAGES + 1) tick();
  endtask

  // Check the three pulse-related outputs plus bin_out after a step.
  task automatic chk_step(input string tag, input logic [3:0] b,
                          input logic ch, input logic u, input logic e);
    chk({tag, "_bin"}, 32'(bus.bin_out), 32'(b));
    chk({tag, "_chg"}, 32'(bus.change),  32'(ch));
    chk({tag, "_up"},  32'(bus.up),      32'(u));
    chk({tag, "_err"}, 32'(bus.err),     32'(e));
  endtask

  function automatic logic [31:0] status();
    return 32'({bus.gray_sync, bus.bin_out, bus.change, bus.up, bus.err});
  endfunction

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.gray_in = 4'b0000;
    bus.err_clr = 1'b0;

    // Reset and idle
    repeat (3) tick();
    chk("rst_status", status(), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_status", status(), 32'h0);
    end

    // Up step 0000 -> 0001: gray_sync after 2 edges, bin_out/change after 3
    bus.gray_in = 4'b0001;
    tick();
    chk("up_chg_e1", 32'(bus.change), 32'h0);
    tick();
    chk("up_gsync_e2", 32'(bus.gray_sync), 32'h1);
    chk("up_bin_e2", 32'(bus.bin_out), 32'h0);
    tick();
    chk_step("up_e3", 4'b0001, 1'b1, 1'b1, 1'b0);
    tick();
    chk("up_chg_e4", 32'(bus.change), 32'h0);

    // Down to 0, then 0 -> 1111 (down wrap), then 1111 -> 0 (up wrap)
    apply(4'b0000);
    chk_step("dn_1to0", 4'b0000, 1'b1, 1'b0, 1'b0);
    apply(4'b1000);
    chk_step("dn_wrap", 4'b1111, 1'b1, 1'b0, 1'b0);
    tick();
    chk("dn_wrap_chg1", 32'(bus.change), 32'h0);
    apply(4'b0000);
    chk_step("up_wrap", 4'b0000, 1'b1, 1'b1, 1'b0);

    // Illegal jump 0 -> 3 (gray 0010)
    apply(4'b0010);
    chk_step("ill_jump", 4'b0011, 1'b1, 1'b0, ERR_EXP);
    tick();
    chk("ill_chg_next", 32'(bus.change), 32'h0);
    chk("ill_err_stay", 32'(bus.err), 32'(ERR_EXP));

    // err_clr clears on the next edge, without touching bin_out/change
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("clr_err", 32'(bus.err), 32'h0);
    chk("clr_bin", 32'(bus.bin_out), 32'h3);
    chk("clr_chg", 32'(bus.change), 32'h0);

    // Set and clear on the same edge: 3 -> 15 is illegal, set wins
    bus.gray_in = 4'b1000;
    tick();
    tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk_step("set_wins", 4'b1111, 1'b1, 1'b0, ERR_EXP);

    // Mid-operation reset with a non-zero word held through release
    bus.gray_in = 4'b0110;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", status(), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("nz_e1", status(), 32'h0);
    tick();
    chk("nz_gsync_e2", 32'(bus.gray_sync), 32'h6);
    chk("nz_bin_e2", 32'(bus.bin_out), 32'h0);
    tick();
    chk_step("nz_e3", 4'b0100, 1'b0, 1'b0, 1'b0);
    tick();
    chk_step("nz_e4", 4'b0100, 1'b0, 1'b0, 1'b0);

    // Back-to-back up steps: bin 4 -> 5 -> 6 on consecutive cycles
    bus.gray_in = 4'b0111;
    tick();
    bus.gray_in = 4'b0101;
    tick();
    tick();
    chk_step("b2b_5", 4'b0101, 1'b1, 1'b1, 1'b0);
    tick();
    chk_step("b2b_6", 4'b0110, 1'b1, 1'b1, 1'b0);
    tick();
    chk("b2b_chg_end", 32'(bus.change), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
